// File: rtl/gbht_predict_ctrl.sv
// gshare BHT controller: clears the 4096x128 pattern array after reset,
// serves predictions, and does RMW counter updates. Optional: GBHT_SPEC_GHR_EN.
module gbht_predict_ctrl #(
    parameter int GHR_W = 12,
    parameter int ROW_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_req,
    input  logic [15:0]      pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [15:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic             init_busy,
    output logic [11:0]      arr_index,
    output logic [11:0]      arr_index_in,
    output logic             arr_write,
    output logic [ROW_W-1:0] arr_datain,
    input  logic [ROW_W-1:0] arr_rdataout,
    input  logic [ROW_W-1:0] arr_dataout
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [11:0]      cnt_q, cnt_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [15:0]      upc_q, upc_d;
    logic [GHR_W-1:0] ughr_q, ughr_d;
    logic             utk_q, utk_d;
    logic             umis_q, umis_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [11:0]      upd_idx;
    logic [5:0]       upd_sel;
    logic [1:0]       old_cnt;
    logic [1:0]       new_cnt;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] pred_row;
    logic [5:0]       pred_sel;
    logic             in_wr;
    logic             in_init;

    // Row index: zero-extended history XOR pc[15:7].
    function automatic logic [11:0] row_idx(
        input logic [15:0]      pc,
        input logic [GHR_W-1:0] g
    );
        logic [11:0] gx;
        gx = '0;
        gx[GHR_W-1:0] = g;
        return gx ^ {3'b000, pc[15:7]};
    endfunction

    // Shift one outcome into a history; degenerates to g <= b for width 1.
    function automatic logic [GHR_W-1:0] ghr_shift(
        input logic [GHR_W-1:0] g,
        input logic             b
    );
        logic [GHR_W-1:0] s;
        s = g << 1;
        s[0] = b;
        return s;
    endfunction

    // Two-bit saturating counter step.
    function automatic logic [1:0] sat_step(
        input logic [1:0] c,
        input logic       t
    );
        logic [1:0] r;
        r = c;
        if (t && c != 2'd3) begin
            r = c + 2'd1;
        end else if (!t && c != 2'd0) begin
            r = c - 2'd1;
        end
        return r;
    endfunction

    assign in_wr   = (state_q == S_WR);
    assign in_init = (state_q == S_INIT);

    // Update-side hash and modified row.
    always_comb begin
        upd_idx = row_idx(upc_q, ughr_q);
        upd_sel = upc_q[6:1];
        old_cnt = row_q[{upd_sel, 1'b0} +: 2];
        new_cnt = sat_step(old_cnt, utk_q);
        wr_row  = row_q;
        wr_row[{upd_sel, 1'b0} +: 2] = new_cnt;
    end

    // Array write port: clear sweep in INIT, modified row in WR.
    always_comb begin
        arr_index_in = upd_idx;
        arr_datain   = '0;
        if (in_init) begin
            arr_index_in = cnt_q;
        end else if (in_wr) begin
            arr_datain = wr_row;
        end
    end

    // Reset gating makes the write enable fall the moment reset asserts.
    assign arr_write = rst_n & (in_init | in_wr);
    assign upd_ready = (state_q == S_IDLE);
    assign init_busy = in_init;

    // Prediction path with bypass of the row being written this cycle.
    always_comb begin
        arr_index = row_idx(pred_pc, ghr_q);
        pred_sel  = pred_pc[6:1];
        pred_row  = arr_rdataout;
        if (in_wr && arr_index == arr_index_in) begin
            pred_row = arr_datain;
        end
        pred_taken = pred_row[{pred_sel, 1'b1}];
    end

    assign pred_valid = pred_req & ~in_init;
    assign pred_ghr   = ghr_q;

    // Sequencer next state and update-register capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upc_d   = upc_q;
        ughr_d  = ughr_q;
        utk_d   = utk_q;
        umis_d  = umis_q;
        row_d   = row_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 12'd1;
                if (cnt_q == 12'hFFF) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (upd_valid) begin
                    upc_d   = upd_pc;
                    ughr_d  = upd_ghr;
                    utk_d   = upd_taken;
                    umis_d  = upd_mispredict;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                row_d   = arr_dataout;
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Global history next value.
    always_comb begin
        ghr_d = ghr_q;
`ifdef GBHT_SPEC_GHR_EN
        if (pred_valid) begin
            ghr_d = ghr_shift(ghr_q, pred_taken);
        end
        if (in_wr && umis_q) begin
            ghr_d = ghr_shift(ughr_q, utk_q);
        end
`else
        if (in_wr) begin
            ghr_d = ghr_shift(ghr_q, utk_q);
        end
`endif
    end

    // State registers; reset aborts any sweep or pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ghr_q   <= '0;
            upc_q   <= '0;
            ughr_q  <= '0;
            utk_q   <= 1'b0;
            umis_q  <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ghr_q   <= ghr_d;
            upc_q   <= upc_d;
            ughr_q  <= ughr_d;
            utk_q   <= utk_d;
            umis_q  <= umis_d;
            row_q   <= row_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pred_pc[0], upc_q[0], umis_q};

endmodule

// File: tb/tb_gbht_predict_ctrl.sv
// Scoreboard bench for gbht_predict_ctrl with a behavioural array model.
// Default build (GBHT_SPEC_GHR_EN undefined), GHR_W = 12.
module tb_gbht_predict_ctrl;

    localparam int GW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pred_req = 1'b0;
    logic [15:0]   pred_pc = '0;
    logic          pred_valid;
    logic          pred_taken;
    logic [GW-1:0] pred_ghr;
    logic          upd_valid = 1'b0;
    logic          upd_ready;
    logic [15:0]   upd_pc = '0;
    logic [GW-1:0] upd_ghr = '0;
    logic          upd_taken = 1'b0;
    logic          upd_mispredict = 1'b0;
    logic          init_busy;
    logic [11:0]   arr_index;
    logic [11:0]   arr_index_in;
    logic          arr_write;
    logic [127:0]  arr_datain;
    logic [127:0]  arr_rdataout;
    logic [127:0]  arr_dataout;

    logic [127:0]  mem [4096];

    typedef struct {
        logic [11:0]  idx;
        logic [127:0] data;
    } wr_t;

    typedef struct {
        logic [11:0]   idx;
        logic          taken;
        logic [GW-1:0] ghr;
    } pr_t;

    wr_t wq[$];
    pr_t pq[$];

    int checks = 0;
    int errors = 0;

    gbht_predict_ctrl #(.GHR_W(GW), .ROW_W(128)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pred_req(pred_req),
        .pred_pc(pred_pc),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_ghr(pred_ghr),
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_pc(upd_pc),
        .upd_ghr(upd_ghr),
        .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict),
        .init_busy(init_busy),
        .arr_index(arr_index),
        .arr_index_in(arr_index_in),
        .arr_write(arr_write),
        .arr_datain(arr_datain),
        .arr_rdataout(arr_rdataout),
        .arr_dataout(arr_dataout)
    );

    always #5 clk = ~clk;

    assign arr_rdataout = mem[arr_index];
    assign arr_dataout  = mem[arr_index_in];

    always @(posedge clk) begin
        if (arr_write) mem[arr_index_in] <= arr_datain;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_wr(input logic [11:0] i, input logic [127:0] d);
        wr_t w;
        w.idx  = i;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic push_pr(input logic [11:0] i, input logic t,
                           input logic [GW-1:0] g);
        pr_t p;
        p.idx   = i;
        p.taken = t;
        p.ghr   = g;
        pq.push_back(p);
    endtask

    task automatic push_init();
        for (int i = 0; i < 4096; i++) push_wr(12'(i), '0);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (init_busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", 128'(n), 128'(4096));
    endtask

    task automatic predict(input logic [15:0] pc);
        pred_req = 1'b1;
        pred_pc  = pc;
        @(posedge clk);
        #1;
        pred_req = 1'b0;
    endtask

    // n back-to-back updates; optional prediction on cycle pcyc.
    task automatic burst(input int n, input logic [15:0] pc,
                         input logic t, input int pcyc,
                         input logic [15:0] ppc);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_ghr        = '0;
        upd_taken      = t;
        upd_mispredict = ~t;
        for (int i = 0; i < 3 * n; i++) begin
            chk("upd_ready", 128'(upd_ready), 128'((i % 3) == 0));
            pred_req = (i == pcyc);
            pred_pc  = ppc;
            @(posedge clk);
            #1;
        end
        upd_valid = 1'b0;
        pred_req  = 1'b0;
    endtask

    // Monitor: pop and compare on every write pulse and valid prediction.
    always @(negedge clk) begin
        if (arr_write) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected idx %0h data %0h",
                         arr_index_in, arr_datain);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_idx", 128'(arr_index_in), 128'(w.idx));
                chk("wr_data", arr_datain, w.data);
            end
        end
        if (pred_valid) begin
            if (pq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pred_unexpected idx %0h taken %0b",
                         arr_index, pred_taken);
            end else begin
                pr_t p;
                p = pq.pop_front();
                chk("pred_idx", 128'(arr_index), 128'(p.idx));
                chk("pred_taken", 128'(pred_taken), 128'(p.taken));
                chk("pred_ghr", 128'(pred_ghr), 128'(p.ghr));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '1;
        #1;
        rst_n    = 1'b0;
        pred_req = 1'b1;
        #2;
        chk("rst_init_busy", 128'(init_busy), 128'(1));
        chk("rst_arr_write", 128'(arr_write), 128'(0));
        chk("rst_upd_ready", 128'(upd_ready), 128'(0));
        chk("rst_pred_valid", 128'(pred_valid), 128'(0));
        chk("rst_ghr", 128'(pred_ghr), 128'(0));
        pred_req = 1'b0;

        push_init();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init();
        chk("idle_ready", 128'(upd_ready), 128'(1));

        push_pr(12'h000, 1'b0, 12'h000);
        predict(16'h0000);

        push_wr(12'h001, 128'h4);
        push_wr(12'h001, 128'h8);
        push_wr(12'h001, 128'hC);
        burst(3, 16'h0082, 1'b1, -1, 16'h0000);
        chk("ghr_3taken", 128'(pred_ghr), 128'h007);

        push_wr(12'h001, 128'hC);
        burst(1, 16'h0082, 1'b1, -1, 16'h0000);
        chk("ghr_4taken", 128'(pred_ghr), 128'h00F);

        push_pr(12'h001, 1'b1, 12'h00F);
        predict(16'h0702);
        push_pr(12'h00E, 1'b0, 12'h00F);
        predict(16'h0082);

        push_wr(12'h001, 128'h8);
        push_wr(12'h001, 128'h4);
        push_pr(12'h001, 1'b0, 12'h01E);
        burst(2, 16'h0082, 1'b0, 5, 16'h0F82);
        chk("ghr_after_nt", 128'(pred_ghr), 128'h03C);

        upd_valid = 1'b1;
        upd_pc    = 16'h0082;
        upd_ghr   = '0;
        upd_taken = 1'b1;
        chk("pre_rd_ready", 128'(upd_ready), 128'(1));
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk("rd_ready", 128'(upd_ready), 128'(0));
        chk("rd_busy", 128'(init_busy), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_write", 128'(arr_write), 128'(0));
        chk("abort_busy", 128'(init_busy), 128'(1));
        chk("abort_ghr", 128'(pred_ghr), 128'(0));
        repeat (3) @(posedge clk);
        push_init();
        #1;
        rst_n = 1'b1;
        wait_init();
        chk("reinit_ghr", 128'(pred_ghr), 128'(0));

        push_wr(12'h001, 128'h4);
        burst(1, 16'h0082, 1'b1, -1, 16'h0000);
        chk("reinit_ghr_1", 128'(pred_ghr), 128'h001);

        repeat (3) @(posedge clk);
        #1;
        chk("wq_empty", 128'(wq.size()), 128'(0));
        chk("pq_empty", 128'(pq.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
